// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: arbiter state encoding and default timeout constants.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_TURN  = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_MASTERS   = 3;
    localparam int DEF_START_TIMEOUT = 16;
    localparam int DEF_HOLD_TIMEOUT  = 1024;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin selection: first requester at or after rr_ptr wins.
module rr_picker #(
    parameter int NUM_MASTERS = 3,
    localparam int IDW = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDW-1:0]         rr_ptr,
    output logic [NUM_MASTERS-1:0] winner,
    output logic [IDW-1:0]         winner_id,
    output logic                   found
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    // Scan masters in priority order rr_ptr, rr_ptr+1, ... wrapping at NUM_MASTERS.
    always_comb begin
        winner    = '0;
        winner_id = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NUM_MASTERS)) begin
                sum = sum - (IDW+1)'(NUM_MASTERS);
            end
            idx = sum[IDW-1:0];
            if (!found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_id   = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with start and hold timeouts and a one-cycle turnaround.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | bus free; arbitrate when slave is ready and a request exists
// ST_GRANT | master granted, waiting for it to start driving (bus_util)
// ST_BUSY  | master driving the bus; tenure length is bounded
// ST_TURN  | one-cycle turnaround with grant low, then back to IDLE
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS   = DEF_NUM_MASTERS,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int HOLD_TIMEOUT  = DEF_HOLD_TIMEOUT,
    localparam int IDW = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   bus_util,
    input  logic                   slave_busy,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDW-1:0]         grant_id,
    output logic                   grant_valid,
    output logic                   timeout_err,
    output logic [IDW-1:0]         err_id
);

    localparam int CNT_MAX = (HOLD_TIMEOUT > START_TIMEOUT) ? HOLD_TIMEOUT : START_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    arb_state_t             state, state_d;
    logic [NUM_MASTERS-1:0] grant_d;
    logic [IDW-1:0]         grant_id_d;
    logic                   grant_valid_d;
    logic                   timeout_err_d;
    logic [IDW-1:0]         err_id_d;
    logic [IDW-1:0]         rr_ptr, rr_ptr_d;
    logic [CW-1:0]          cnt, cnt_d, cnt_inc;
    logic                   leave, abort;

    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDW-1:0]         pick_id;
    logic                   pick_found;

    rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_rr_picker (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .winner    (pick_onehot),
        .winner_id (pick_id),
        .found     (pick_found)
    );

    // The shared counter never wraps; in practice the state is left before it saturates.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // Next-state, counter and output decode.
    always_comb begin
        state_d       = state;
        grant_d       = grant;
        grant_id_d    = grant_id;
        timeout_err_d = 1'b0;
        err_id_d      = err_id;
        rr_ptr_d      = rr_ptr;
        cnt_d         = cnt;
        leave         = 1'b0;
        abort         = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (!slave_busy && pick_found) begin
                    state_d    = ST_GRANT;
                    grant_d    = pick_onehot;
                    grant_id_d = pick_id;
                end
            end
            ST_GRANT: begin
                // bus_util wins over a timeout expiring in the same cycle
                if (bus_util) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                end else if (!req[grant_id]) begin
                    leave = 1'b1;
                end else if (cnt >= CW'(START_TIMEOUT - 1)) begin
                    leave = 1'b1;
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_BUSY: begin
                if (!bus_util) begin
                    leave = 1'b1;
                end else if (cnt >= CW'(HOLD_TIMEOUT - 1)) begin
                    leave = 1'b1;
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
        // The served master drops to lowest priority for the next arbitration.
        if (leave) begin
            state_d    = ST_TURN;
            grant_d    = '0;
            grant_id_d = '0;
            cnt_d      = '0;
            rr_ptr_d   = (grant_id == IDW'(NUM_MASTERS - 1)) ? '0 : grant_id + 1'b1;
        end
        if (abort) begin
            timeout_err_d = 1'b1;
            err_id_d      = grant_id;
        end
        grant_valid_d = |grant_d;
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout_err <= 1'b0;
            err_id      <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_d;
            grant       <= grant_d;
            grant_id    <= grant_id_d;
            grant_valid <= grant_valid_d;
            timeout_err <= timeout_err_d;
            err_id      <= err_id_d;
            rr_ptr      <= rr_ptr_d;
            cnt         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized stress
// against a cycle-count reference model of the arbitration rules.
module tb_bus_arbiter;

    localparam int N  = 3;
    localparam int ST = 16;
    localparam int HT = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         bus_util;
    logic         slave_busy;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         grant_valid;
    logic         timeout_err;
    logic [1:0]   err_id;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.NUM_MASTERS(N), .START_TIMEOUT(ST), .HOLD_TIMEOUT(HT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .bus_util    (bus_util),
        .slave_busy  (slave_busy),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout_err (timeout_err),
        .err_id      (err_id)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; bus_util = 1'b0; slave_busy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int pick(logic [N-1:0] r, int p);
        for (int i = 0; i < N; i++) begin
            int m;
            m = (p + i) % N;
            if (r[m]) return m;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; req = 3'b111; bus_util = 1'b1; slave_busy = 1'b0;
        tick();
        tick();
        checks++;
        if (grant !== 3'b000 || grant_valid !== 1'b0 || grant_id !== 2'd0 ||
            timeout_err !== 1'b0 || err_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: grant=%b valid=%b id=%0d err=%b eid=%0d, want all zero",
                     grant, grant_valid, grant_id, timeout_err, err_id);
        end
        rst = 1'b0; req = '0; bus_util = 1'b0;
    endtask

    task automatic test_round_robin();
        int order[4] = '{0, 1, 2, 0};
        logic [N-1:0] exp_g;
        bit held;
        do_reset();
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            exp_g = 3'b001 << order[i];
            tick();
            checks++;
            if (grant !== exp_g || grant_id !== 2'(order[i]) || grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant[%0d]: grant=%b id=%0d valid=%b, want grant=%b id=%0d valid=1",
                         i, grant, grant_id, grant_valid, exp_g, order[i]);
            end
            bus_util = 1'b1;
            held = 1'b1;
            repeat (4) begin
                tick();
                if (grant !== exp_g || timeout_err !== 1'b0) held = 1'b0;
            end
            checks++;
            if (!held) begin
                errors++;
                $display("FAIL rr_hold[%0d]: grant=%b, want %b held with no error", i, grant, exp_g);
            end
            bus_util = 1'b0;
            tick();
            checks++;
            if (grant !== 3'b000 || grant_valid !== 1'b0 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL rr_turn[%0d]: grant=%b valid=%b err=%b, want 000/0/0",
                         i, grant, grant_valid, timeout_err);
            end
            if (i == 3) req = '0;
            tick();
            checks++;
            if (grant !== 3'b000) begin
                errors++;
                $display("FAIL rr_gap[%0d]: grant=%b, want 000", i, grant);
            end
        end
    endtask

    task automatic test_start_timeout();
        bit ok;
        do_reset();
        req = 3'b010;
        tick();
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("FAIL start_grant: grant=%b, want 010", grant);
        end
        ok = 1'b1;
        repeat (ST - 1) begin
            tick();
            if (grant !== 3'b010 || timeout_err !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL start_wait: grant=%b err=%b, want 010 held without error", grant, timeout_err);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || err_id !== 2'd1 || grant !== 3'b000) begin
            errors++;
            $display("FAIL start_timeout: err=%b eid=%0d grant=%b, want 1/1/000", timeout_err, err_id, grant);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0 || grant !== 3'b000) begin
            errors++;
            $display("FAIL start_pulse: err=%b grant=%b, want 0/000", timeout_err, grant);
        end
        tick();
        checks++;
        if (grant !== 3'b010 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL start_regrant: grant=%b id=%0d, want 010/1", grant, grant_id);
        end
        req = '0;
    endtask

    task automatic test_util_precedence();
        do_reset();
        req = 3'b001;
        tick();
        repeat (ST - 1) tick();
        bus_util = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b001 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL util_precedence: grant=%b err=%b, want 001/0", grant, timeout_err);
        end
        bus_util = 1'b0;
        tick();
        checks++;
        if (grant !== 3'b000 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL util_release: grant=%b err=%b, want 000/0", grant, timeout_err);
        end
        tick();
        req = 3'b010;
        tick();
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("FAIL drop_grant: grant=%b, want 010", grant);
        end
        req = 3'b000;
        tick();
        checks++;
        if (grant !== 3'b000 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL req_drop: grant=%b err=%b, want 000/0", grant, timeout_err);
        end
    endtask

    task automatic test_hold_timeout();
        bit ok;
        do_reset();
        req = 3'b001;
        tick();
        req = 3'b011;
        bus_util = 1'b1;
        tick();
        ok = (grant === 3'b001);
        repeat (HT - 1) begin
            tick();
            if (grant !== 3'b001 || timeout_err !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_tenure: grant=%b err=%b, want 001 held without error", grant, timeout_err);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || err_id !== 2'd0 || grant !== 3'b000) begin
            errors++;
            $display("FAIL hold_timeout: err=%b eid=%0d grant=%b, want 1/0/000", timeout_err, err_id, grant);
        end
        bus_util = 1'b0;
        tick();
        checks++;
        if (grant !== 3'b000 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL hold_turn: grant=%b err=%b, want 000/0", grant, timeout_err);
        end
        tick();
        checks++;
        if (grant !== 3'b010 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL hold_next: grant=%b id=%0d, want 010/1", grant, grant_id);
        end
        req = '0;
    endtask

    task automatic test_slave_busy();
        bit ok;
        do_reset();
        slave_busy = 1'b1;
        req = 3'b100;
        ok = 1'b1;
        repeat (5) begin
            tick();
            if (grant !== 3'b000 || grant_valid !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_block: grant=%b, want 000 while slave busy", grant);
        end
        slave_busy = 1'b0;
        tick();
        checks++;
        if (grant !== 3'b100 || grant_id !== 2'd2 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL busy_release: grant=%b id=%0d valid=%b, want 100/2/1", grant, grant_id, grant_valid);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_tenure();
        do_reset();
        req = 3'b001;
        tick();
        bus_util = 1'b1;
        tick();
        bus_util = 1'b0;
        tick();
        tick();
        req = 3'b100;
        tick();
        checks++;
        if (grant !== 3'b100) begin
            errors++;
            $display("FAIL midrst_grant: grant=%b, want 100", grant);
        end
        bus_util = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b000 || grant_valid !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_drop: grant=%b valid=%b err=%b, want 000/0/0", grant, grant_valid, timeout_err);
        end
        rst = 1'b0;
        bus_util = 1'b0;
        req = 3'b111;
        tick();
        checks++;
        if (grant !== 3'b001 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL midrst_restart: grant=%b id=%0d, want 001/0", grant, grant_id);
        end
        req = '0;
    endtask

    task automatic test_random_stress();
        int owner, cnt, rr, w, start_err;
        bit started, in_turn, rel, rel_err;
        logic [N-1:0] exp_g, prev_grant;
        logic [1:0] exp_id, exp_eid;
        logic exp_err;
        int waits[N];
        do_reset();
        owner = -1; cnt = 0; rr = 0; started = 1'b0; in_turn = 1'b0;
        exp_eid = 2'd0; prev_grant = '0; start_err = errors;
        for (int m = 0; m < N; m++) waits[m] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int m = 0; m < N; m++) if ($urandom_range(0, 9) == 0) req[m] = ~req[m];
            slave_busy = ($urandom_range(0, 5) == 0);
            if (owner < 0)     bus_util = 1'b0;
            else if (!started) bus_util = ($urandom_range(0, 9) == 0);
            else               bus_util = ($urandom_range(0, 5) != 0);

            exp_err = 1'b0; rel = 1'b0; rel_err = 1'b0;
            if (owner < 0) begin
                if (in_turn) in_turn = 1'b0;
                else if (!slave_busy && req != '0) begin
                    owner = pick(req, rr); started = 1'b0; cnt = 0;
                end
            end else begin
                cnt++;
                if (!started) begin
                    if (bus_util) begin started = 1'b1; cnt = 0; end
                    else if (!req[owner]) rel = 1'b1;
                    else if (cnt == ST) begin rel = 1'b1; rel_err = 1'b1; end
                end else begin
                    if (!bus_util) rel = 1'b1;
                    else if (cnt == HT) begin rel = 1'b1; rel_err = 1'b1; end
                end
                if (rel) begin
                    rr = (owner + 1) % N;
                    if (rel_err) begin exp_err = 1'b1; exp_eid = 2'(owner); end
                    owner = -1; in_turn = 1'b1;
                end
            end
            exp_g  = (owner >= 0) ? (3'b001 << owner) : 3'b000;
            exp_id = (owner >= 0) ? 2'(owner) : 2'd0;

            tick();
            checks++;
            if (grant !== exp_g || grant_id !== exp_id || grant_valid !== (owner >= 0) ||
                timeout_err !== exp_err || err_id !== exp_eid) begin
                errors++;
                $display("FAIL stress cycle %0d: grant=%b id=%0d valid=%b err=%b eid=%0d, want grant=%b id=%0d err=%b eid=%0d",
                         cyc, grant, grant_id, grant_valid, timeout_err, err_id, exp_g, exp_id, exp_err, exp_eid);
            end
            checks++;
            if (!$onehot0(grant)) begin
                errors++;
                $display("FAIL stress_onehot cycle %0d: grant=%b, want one-hot or zero", cyc, grant);
            end
            if (grant != '0 && prev_grant == '0 && $onehot(grant)) begin
                w = 0;
                for (int m = 0; m < N; m++) if (grant[m]) w = m;
                for (int m = 0; m < N; m++) begin
                    if (m == w) waits[m] = 0;
                    else if (req[m]) waits[m]++;
                    else waits[m] = 0;
                end
                for (int m = 0; m < N; m++) begin
                    checks++;
                    if (waits[m] > N - 1) begin
                        errors++;
                        $display("FAIL stress_fairness cycle %0d: master %0d waited %0d tenures, limit %0d",
                                 cyc, m, waits[m], N - 1);
                    end
                end
            end
            prev_grant = grant;
            if (errors - start_err > 20) break;
        end
        req = '0;
        bus_util = 1'b0;
        slave_busy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; bus_util = 1'b0; slave_busy = 1'b0;
        test_reset();
        test_round_robin();
        test_start_timeout();
        test_util_precedence();
        test_hold_timeout();
        test_slave_busy();
        test_reset_mid_tenure();
        test_random_stress();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
